aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//   Sequencer for a byte-serial AES-128/192/256 encryption datapath. One
//   start pulse in IDLE runs one 16-byte block: LOAD (plaintext entry), NR-1
//   ROUND passes with mix-column, one FINAL pass, then PIPE_LAT DRAIN cycles
//   while the last results leave the datapath pipeline, and a one-cycle DONE.
//
//   Parameters
//     NR        number of AES rounds (2..14)
//     PIPE_LAT  datapath latency in cycles from data_in to data_iout (1..7)
//
//   Ports
//     clk            rising-edge clock
//     rst            synchronous active-low reset
//     start          one-cycle request to encrypt a block (honoured in IDLE only)
//     in_ready       datapath accepts a plaintext byte this cycle
//     pld            parallel-load strobe for the parallel-to-serial converter
//     c3             shift-row column select
//     mix_column_en  byte-wide mix-column enable mask
//     key_addr       round-key byte address {round, byte_cnt}
//     last_round     final round, selects the round_key_last_out path
//     out_valid      data_iout carries a ciphertext byte
//     busy           controller is not idle
//     done           one-cycle pulse after the last ciphertext byte
//
//   All outputs are flops. They are computed from the next-state values so
//   that each output lines up with the state it describes in the same cycle.
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int NR       = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       in_ready,
  output logic       pld,
  output logic [1:0] c3,
  output logic [7:0] mix_column_en,
  output logic [7:0] key_addr,
  output logic       last_round,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] LAST_MID_ROUND = 4'(NR - 1);
  localparam logic [3:0] FINAL_ROUND    = 4'(NR);
  localparam logic [2:0] DRAIN_LAST     = 3'(PIPE_LAT - 1);

  state_t              state_r, state_s;
  logic [3:0]          byte_cnt_r, byte_cnt_s;
  logic [3:0]          round_r, round_s;
  logic [2:0]          drain_cnt_r, drain_cnt_s;
  logic [PIPE_LAT-1:0] final_dly_r;

  logic       in_ready_s, pld_s, last_round_s, busy_s, done_s;
  logic [1:0] c3_s;
  logic [7:0] mix_column_en_s, key_addr_s;

  // Next-state and counter update
  always_comb begin
    state_s     = state_r;
    byte_cnt_s  = byte_cnt_r;
    round_s     = round_r;
    drain_cnt_s = drain_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_LOAD;
          byte_cnt_s = 4'd0;
          round_s    = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        byte_cnt_s = byte_cnt_r + 4'd1;
        if (byte_cnt_r == 4'd15) begin
          // Even with NR=2 there is one mix-column round before FINAL.
          state_s = ST_ROUND;
          round_s = 4'd1;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_ROUND: begin
        byte_cnt_s = byte_cnt_r + 4'd1;
        if (byte_cnt_r == 4'd15) begin
          if (round_r == LAST_MID_ROUND) begin
            state_s = ST_FINAL;
            round_s = FINAL_ROUND;
          end else begin
            state_s = ST_ROUND;
            round_s = round_r + 4'd1;
          end
        end else begin
          state_s = ST_ROUND;
        end
      end
      ST_FINAL: begin
        byte_cnt_s = byte_cnt_r + 4'd1;
        if (byte_cnt_r == 4'd15) begin
          state_s     = ST_DRAIN;
          drain_cnt_s = 3'd0;
        end else begin
          state_s = ST_FINAL;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) begin
          state_s = ST_DONE;
        end else begin
          drain_cnt_s = drain_cnt_r + 3'd1;
        end
      end
      ST_DONE: begin
        // A start seen here is dropped; a new block must be requested in IDLE.
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the flopped outputs match it
  always_comb begin
    in_ready_s      = 1'b0;
    pld_s           = 1'b0;
    c3_s            = 2'b00;
    mix_column_en_s = 8'h00;
    key_addr_s      = 8'h00;
    last_round_s    = 1'b0;
    done_s          = 1'b0;
    busy_s          = (state_s != ST_IDLE);
    case (state_s)
      ST_LOAD: begin
        in_ready_s = 1'b1;
        c3_s       = byte_cnt_s[3:2];
        key_addr_s = {round_s, byte_cnt_s};
      end
      ST_ROUND: begin
        c3_s            = byte_cnt_s[3:2];
        key_addr_s      = {round_s, byte_cnt_s};
        mix_column_en_s = 8'hFF;
        // Converter reloads after every fourth byte (end of a column).
        pld_s           = (byte_cnt_s[1:0] == 2'b11);
      end
      ST_FINAL: begin
        c3_s         = byte_cnt_s[3:2];
        key_addr_s   = {round_s, byte_cnt_s};
        last_round_s = 1'b1;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      byte_cnt_r    <= 4'd0;
      round_r       <= 4'd0;
      drain_cnt_r   <= 3'd0;
      in_ready      <= 1'b0;
      pld           <= 1'b0;
      c3            <= 2'b00;
      mix_column_en <= 8'h00;
      key_addr      <= 8'h00;
      last_round    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_r       <= state_s;
      byte_cnt_r    <= byte_cnt_s;
      round_r       <= round_s;
      drain_cnt_r   <= drain_cnt_s;
      in_ready      <= in_ready_s;
      pld           <= pld_s;
      c3            <= c3_s;
      mix_column_en <= mix_column_en_s;
      key_addr      <= key_addr_s;
      last_round    <= last_round_s;
      busy          <= busy_s;
      done          <= done_s;
    end
  end

  // out_valid tracks FINAL through a PIPE_LAT-deep delay line (the datapath latency)
  generate
    if (PIPE_LAT == 1) begin : g_dly_one
      // Single-stage delay line
      always_ff @(posedge clk) begin
        if (!rst) begin
          final_dly_r <= 1'b0;
        end else begin
          final_dly_r <= (state_r == ST_FINAL);
        end
      end
    end else begin : g_dly_multi
      // Multi-stage delay line, bit k is FINAL delayed by k+1 cycles
      always_ff @(posedge clk) begin
        if (!rst) begin
          final_dly_r <= '0;
        end else begin
          final_dly_r <= {final_dly_r[PIPE_LAT-2:0], (state_r == ST_FINAL)};
        end
      end
    end
  endgenerate

  assign out_valid = final_dly_r[PIPE_LAT-1];

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  localparam int NR_A  = 10;
  localparam int PL_A  = 2;
  localparam int NR_B  = 2;
  localparam int PL_B  = 1;
  // Cycle index (1 = first LOAD cycle) of the DONE cycle: 16 LOAD + 16*(NR-1) ROUND + 16 FINAL + PL + 1
  localparam int TOT_A = 16 + 16 * (NR_A - 1) + 16 + PL_A + 1;
  localparam int TOT_B = 16 + 16 * (NR_B - 1) + 16 + PL_B + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;

  logic       ir_a, pld_a, lr_a, ov_a, busy_a, done_a;
  logic [1:0] c3_a;
  logic [7:0] mce_a, ka_a;
  logic       ir_b, pld_b, lr_b, ov_b, busy_b, done_b;
  logic [1:0] c3_b;
  logic [7:0] mce_b, ka_b;
  logic [23:0] vec_a, vec_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_a = 0;  // model position inside a block for DUT A, 0 = idle
  int m_b = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR_A), .PIPE_LAT(PL_A)) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .in_ready(ir_a), .pld(pld_a), .c3(c3_a), .mix_column_en(mce_a),
    .key_addr(ka_a), .last_round(lr_a), .out_valid(ov_a),
    .busy(busy_a), .done(done_a)
  );

  aes_round_ctrl #(.NR(NR_B), .PIPE_LAT(PL_B)) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .in_ready(ir_b), .pld(pld_b), .c3(c3_b), .mix_column_en(mce_b),
    .key_addr(ka_b), .last_round(lr_b), .out_valid(ov_b),
    .busy(busy_b), .done(done_b)
  );

  assign vec_a = {ir_a, pld_a, c3_a, mce_a, ka_a, lr_a, ov_a, busy_a, done_a};
  assign vec_b = {ir_b, pld_b, c3_b, mce_b, ka_b, lr_b, ov_b, busy_b, done_b};

  // Reference: position in block after one clock edge
  function automatic int next_t(logic r, logic s, int t, int tot);
    if (!r) return 0;
    if (t == 0) return s ? 1 : 0;
    if (t >= tot) return 0;
    return t + 1;
  endfunction

  // Reference: all outputs for position t of a block
  function automatic logic [23:0] exp_vec(int nr, int pl, int t);
    int fs, b, rnd;
    logic ir, pd, lr, ov, bz, dn;
    logic [1:0] c3;
    logic [7:0] mc, ka;
    fs = 16 * nr + 1;
    ir = 1'b0; pd = 1'b0; lr = 1'b0; c3 = 2'd0; mc = 8'h00; ka = 8'h00;
    b = 0; rnd = 0;
    bz = (t > 0);
    dn = (t == 16 * nr + 17 + pl);
    if (t >= 1 && t <= 16) begin
      ir = 1'b1; b = t - 1; rnd = 0;
    end else if (t >= 17 && t < fs) begin
      b = (t - 17) % 16; rnd = 1 + (t - 17) / 16; mc = 8'hFF; pd = (b % 4 == 3);
    end else if (t >= fs && t < fs + 16) begin
      b = t - fs; rnd = nr; lr = 1'b1;
    end
    if (t >= 1 && t < fs + 16) begin
      c3 = 2'(b / 4);
      ka = 8'(rnd * 16 + b);
    end
    ov = (t >= fs + pl && t < fs + pl + 16);
    return {ir, pd, c3, mc, ka, lr, ov, bz, dn};
  endfunction

  // Advance one clock and move both reference positions
  task automatic tick();
    logic r, s;
    r = rst;
    s = start;
    @(posedge clk);
    #1;
    m_a = next_t(r, s, m_a, TOT_A);
    m_b = next_t(r, s, m_b, TOT_B);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1;
    tick(); tick();
    checks++;
    if (vec_a !== 24'h0) begin failures++; $display("FAIL reset_a got=%h exp=%h", vec_a, 24'h0); end
    checks++;
    if (vec_b !== 24'h0) begin failures++; $display("FAIL reset_b got=%h exp=%h", vec_b, 24'h0); end
    rst = 1'b1; start = 1'b0;
    tick(); tick();
    checks++;
    if (vec_a !== 24'h0) begin failures++; $display("FAIL reset_hold got=%h exp=%h", vec_a, 24'h0); end
  endtask

  task automatic test_single_block();
    int s0, n_ir, n_pld, n_lr, n_ov, n_done, done_at, first_ir, last_ov, n_pld_b, done_b_at;
    n_ir = 0; n_pld = 0; n_lr = 0; n_ov = 0; n_done = 0; done_at = -1;
    first_ir = -1; last_ov = -1; n_pld_b = 0; done_b_at = -1;
    start = 1'b1; s0 = cyc; tick(); start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ir_a === 1'b1) begin n_ir++; if (first_ir < 0) first_ir = cyc - s0; end
      if (pld_a === 1'b1) n_pld++;
      if (lr_a === 1'b1) n_lr++;
      if (ov_a === 1'b1) begin n_ov++; last_ov = cyc - s0; end
      if (done_a === 1'b1) begin n_done++; if (done_at < 0) done_at = cyc - s0; end
      if (pld_b === 1'b1) n_pld_b++;
      if (done_b === 1'b1 && done_b_at < 0) done_b_at = cyc - s0;
      tick();
    end
    checks++; if (n_ir != 16) begin failures++; $display("FAIL in_ready_count got=%0d exp=%0d", n_ir, 16); end
    checks++; if (first_ir != 1) begin failures++; $display("FAIL in_ready_first got=%0d exp=%0d", first_ir, 1); end
    checks++; if (n_pld != 4 * (NR_A - 1)) begin failures++; $display("FAIL pld_count got=%0d exp=%0d", n_pld, 4 * (NR_A - 1)); end
    checks++; if (n_lr != 16) begin failures++; $display("FAIL last_round_count got=%0d exp=%0d", n_lr, 16); end
    checks++; if (n_ov != 16) begin failures++; $display("FAIL out_valid_count got=%0d exp=%0d", n_ov, 16); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL done_count got=%0d exp=%0d", n_done, 1); end
    checks++; if (done_at != TOT_A) begin failures++; $display("FAIL done_cycle got=%0d exp=%0d", done_at, TOT_A); end
    checks++; if (last_ov != TOT_A - 1) begin failures++; $display("FAIL out_valid_last got=%0d exp=%0d", last_ov, TOT_A - 1); end
    checks++; if (n_pld_b != 4) begin failures++; $display("FAIL nr2_pld_count got=%0d exp=%0d", n_pld_b, 4); end
    checks++; if (done_b_at != TOT_B) begin failures++; $display("FAIL nr2_done_cycle got=%0d exp=%0d", done_b_at, TOT_B); end
  endtask

  task automatic test_schedule();
    bit found;
    start = 1'b1; tick(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (ka_a === 8'h30 && mce_a === 8'hFF) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL sched_sync got=timeout exp=key_addr_30"); end
    else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (ka_a !== 8'(8'h30 + i)) begin failures++; $display("FAIL sched_key i=%0d got=%h exp=%h", i, ka_a, 8'(8'h30 + i)); end
        checks++;
        if (c3_a !== 2'(i / 4)) begin failures++; $display("FAIL sched_c3 i=%0d got=%0d exp=%0d", i, c3_a, i / 4); end
        checks++;
        if (pld_a !== (i % 4 == 3)) begin failures++; $display("FAIL sched_pld i=%0d got=%b exp=%b", i, pld_a, (i % 4 == 3)); end
        tick();
      end
    end
    for (int i = 0; i < 300 && busy_a !== 1'b0; i++) tick();
  endtask

  task automatic test_start_ignored();
    int s0, n_done, done_at;
    bit found, after_done;
    start = 1'b1; s0 = cyc; tick(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (ka_a === 8'h53 && mce_a === 8'hFF) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL busy_start_sync got=timeout exp=round5"); end
    start = 1'b1; tick(); start = 1'b0;
    n_done = 0; done_at = -1; after_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (after_done) begin
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL start_in_done got=busy%b exp=busy0", busy_a); end
        after_done = 1'b0;
      end
      start = 1'b0;
      if (done_a === 1'b1) begin
        n_done++; done_at = cyc - s0;
        start = 1'b1;  // lands in the DONE cycle
        after_done = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    checks++; if (n_done != 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=%0d", n_done, 1); end
    checks++; if (done_at != TOT_A) begin failures++; $display("FAIL busy_start_done_cycle got=%0d exp=%0d", done_at, TOT_A); end
    for (int i = 0; i < 300 && (busy_a !== 1'b0 || busy_b !== 1'b0); i++) tick();
  endtask

  task automatic test_mid_reset();
    int s0, n_ov, done_at;
    bit found;
    start = 1'b1; tick(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (ka_a === 8'h49 && mce_a === 8'hFF) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mid_reset_sync got=timeout exp=round4_byte9"); end
    rst = 1'b0; tick(); rst = 1'b1;
    checks++;
    if (vec_a !== 24'h0) begin failures++; $display("FAIL mid_reset_outputs got=%h exp=%h", vec_a, 24'h0); end
    tick();
    checks++;
    if (vec_a !== 24'h0) begin failures++; $display("FAIL mid_reset_idle got=%h exp=%h", vec_a, 24'h0); end
    start = 1'b1; s0 = cyc; tick(); start = 1'b0;
    checks++;
    if (vec_a !== exp_vec(NR_A, PL_A, 1)) begin failures++; $display("FAIL restart_first got=%h exp=%h", vec_a, exp_vec(NR_A, PL_A, 1)); end
    n_ov = 0; done_at = -1;
    for (int i = 0; i < 200; i++) begin
      if (ov_a === 1'b1) n_ov++;
      if (done_a === 1'b1 && done_at < 0) done_at = cyc - s0;
      tick();
    end
    checks++; if (n_ov != 16) begin failures++; $display("FAIL restart_out_valid got=%0d exp=%0d", n_ov, 16); end
    checks++; if (done_at != TOT_A) begin failures++; $display("FAIL restart_done_cycle got=%0d exp=%0d", done_at, TOT_A); end
  endtask

  task automatic test_back_to_back();
    int s0, s1, d1, d2, n_ov, n_overlap;
    start = 1'b1; s0 = cyc; tick(); start = 1'b0;
    d1 = -1;
    for (int i = 0; i < 250 && d1 < 0; i++) begin
      if (done_a === 1'b1) d1 = cyc - s0;
      else tick();
    end
    tick();
    start = 1'b1; s1 = cyc; tick(); start = 1'b0;
    d2 = -1; n_ov = 0; n_overlap = 0;
    for (int i = 0; i < 200; i++) begin
      if (ov_a === 1'b1) n_ov++;
      if (ov_a === 1'b1 && (ir_a === 1'b1 || mce_a !== 8'h00)) n_overlap++;
      if (done_a === 1'b1 && d2 < 0) d2 = cyc - s1;
      tick();
    end
    checks++; if (d1 != TOT_A) begin failures++; $display("FAIL b2b_done1 got=%0d exp=%0d", d1, TOT_A); end
    checks++; if (s1 - s0 != TOT_A + 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", s1 - s0, TOT_A + 1); end
    checks++; if (d2 != TOT_A) begin failures++; $display("FAIL b2b_done2 got=%0d exp=%0d", d2, TOT_A); end
    checks++; if (n_ov != 16) begin failures++; $display("FAIL b2b_out_valid got=%0d exp=%0d", n_ov, 16); end
    checks++; if (n_overlap != 0) begin failures++; $display("FAIL b2b_overlap got=%0d exp=%0d", n_overlap, 0); end
  endtask

  task automatic test_random();
    logic [23:0] ea, eb;
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 11) == 0);
      rst   = ($urandom_range(0, 399) != 0);
      tick();
      ea = exp_vec(NR_A, PL_A, m_a);
      eb = exp_vec(NR_B, PL_B, m_b);
      checks++;
      if (vec_a !== ea) begin failures++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", cyc, vec_a, ea); end
      checks++;
      if (vec_b !== eb) begin failures++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", cyc, vec_b, eb); end
    end
    start = 1'b0; rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_schedule();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
